// File: rtl/crp16_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : crp16_mem_arbiter
// Brief   : Shares one single-port synchronous memory between the CRP16 fetch
//           port and the load/store port. Each access runs ISSUE/WAIT/RESPOND.
//           Define CRP16_MEM_ARB_RR_EN for round-robin tie-breaking
//           (default: data port wins every tie).
// Revision: 1.0  initial release
// ============================================================================
module crp16_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
            $error("crp16_mem_arbiter: MEM_LATENCY must be 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] c_WAIT_INIT = 2'(MEM_LATENCY - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_cnt;
    logic       r_owner_d;
    logic       r_we;
    logic       w_grant_d;

`ifdef CRP16_MEM_ARB_RR_EN
    logic       r_last_d;

    // Last-grant starts at DATA so the first tie after reset goes to fetch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_d <= 1'b1;
        end else if (r_state == S_IDLE && w_next_state == S_ACCESS) begin
            r_last_d <= w_grant_d;
        end
    end
`endif

    always_comb begin
        w_grant_d = d_req;
`ifdef CRP16_MEM_ARB_RR_EN
        if (i_req && d_req) begin
            w_grant_d = ~r_last_d;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_req || d_req) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = S_WAIT;
            S_WAIT:   if (r_cnt == 2'd0) w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so each is a plain flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= 2'd0;
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;
            busy   <= (w_next_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_next_state == S_ACCESS) begin
                        r_owner_d <= w_grant_d;
                        r_we      <= w_grant_d & d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= w_grant_d & d_we;
                        mem_addr  <= w_grant_d ? d_addr : i_addr;
                        if (w_grant_d) begin
                            mem_wdata <= d_wdata;
                        end
                    end
                end
                S_ACCESS: r_cnt <= c_WAIT_INIT;
                S_WAIT: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else begin
                        if (!r_we && r_owner_d)  d_rdata <= mem_rdata;
                        if (!r_we && !r_owner_d) i_rdata <= mem_rdata;
                        d_ack <= r_owner_d;
                        i_ack <= ~r_owner_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crp16_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_crp16_mem_arbiter
// Brief   : Directed self-checking bench; DUT A uses MEM_LATENCY=1, DUT B uses 3.
// Revision: 1.0  initial release
// ============================================================================
module tb_crp16_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // DUT A (MEM_LATENCY = 1)
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_en, mem_we, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] mem_a [0:65535];

    crp16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1)) u_dut_a (
        .clock(clock), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem_a[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_a[mem_addr];
        end
    end

    // DUT B (MEM_LATENCY = 3), fetch port only
    logic        b_i_req, b_d_req, b_d_we;
    logic [15:0] b_i_addr, b_d_addr, b_d_wdata;
    logic        b_i_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;
    logic [15:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [15:0] b_p0, b_p1;
    logic [15:0] mem_b [0:65535];

    crp16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(3)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    always @(posedge clock) begin
        if (b_mem_en) begin
            if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
            else          b_p0 <= mem_b[b_mem_addr];
        end
        b_p1        <= b_p0;
        b_mem_rdata <= b_p1;
    end

    // Per-cycle capture of DUT A, bit c = cycle c after the request cycle
    logic [15:0] v_i_ack, v_d_ack, v_en, v_we, v_busy;
    logic [15:0] addr_c1;

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic start_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic capture(input int n, input bit auto_drop);
        v_i_ack = '0; v_d_ack = '0; v_en = '0; v_we = '0; v_busy = '0; addr_c1 = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            v_i_ack[c] = i_ack;
            v_d_ack[c] = d_ack;
            v_en[c]    = mem_en;
            v_we[c]    = mem_we;
            v_busy[c]  = busy;
            if (c == 1) addr_c1 = mem_addr;
            if (auto_drop && i_ack) i_req = 1'b0;
            if (auto_drop && d_ack) d_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, mem_en, mem_we, i_ack, d_ack} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {busy, mem_en, mem_we, i_ack, d_ack});
        end
        checks++;
        if ({i_rdata, d_rdata} !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=00000000", {i_rdata, d_rdata});
        end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_fetch();
        mem_a[16'h0040] = 16'hBEEF;
        start_cycle();
        i_addr = 16'h0040; i_req = 1'b1;
        capture(6, 1'b1);
        checks++;
        if (v_en[5:0] !== 6'b000010) begin
            failures++; $display("FAIL fetch_en got=%b exp=000010", v_en[5:0]);
        end
        checks++;
        if (v_we[5:0] !== 6'b000000) begin
            failures++; $display("FAIL fetch_we got=%b exp=000000", v_we[5:0]);
        end
        checks++;
        if (addr_c1 !== 16'h0040) begin
            failures++; $display("FAIL fetch_addr got=%h exp=0040", addr_c1);
        end
        checks++;
        if (v_i_ack[5:0] !== 6'b001000) begin
            failures++; $display("FAIL fetch_iack got=%b exp=001000", v_i_ack[5:0]);
        end
        checks++;
        if (v_d_ack[5:0] !== 6'b000000) begin
            failures++; $display("FAIL fetch_dack got=%b exp=000000", v_d_ack[5:0]);
        end
        checks++;
        if (v_busy[5:0] !== 6'b001110) begin
            failures++; $display("FAIL fetch_busy got=%b exp=001110", v_busy[5:0]);
        end
        checks++;
        if (i_rdata !== 16'hBEEF) begin
            failures++; $display("FAIL fetch_rdata got=%h exp=beef", i_rdata);
        end
    endtask

    task automatic test_store_load();
        start_cycle();
        d_we = 1'b1; d_addr = 16'h1234; d_wdata = 16'hA5A5; d_req = 1'b1;
        capture(6, 1'b1);
        checks++;
        if (v_we[5:0] !== 6'b000010) begin
            failures++; $display("FAIL store_we got=%b exp=000010", v_we[5:0]);
        end
        checks++;
        if (v_d_ack[5:0] !== 6'b001000) begin
            failures++; $display("FAIL store_dack got=%b exp=001000", v_d_ack[5:0]);
        end
        checks++;
        if (mem_a[16'h1234] !== 16'hA5A5) begin
            failures++; $display("FAIL store_mem got=%h exp=a5a5", mem_a[16'h1234]);
        end
        checks++;
        if (d_rdata !== 16'h0000) begin
            failures++; $display("FAIL store_rdata got=%h exp=0000", d_rdata);
        end
        start_cycle();
        d_we = 1'b0; d_wdata = 16'h0000; d_req = 1'b1;
        capture(6, 1'b1);
        checks++;
        if (v_d_ack[5:0] !== 6'b001000 || v_we[5:0] !== 6'b000000) begin
            failures++; $display("FAIL load_ack_we got=%b/%b exp=001000/000000", v_d_ack[5:0], v_we[5:0]);
        end
        checks++;
        if (d_rdata !== 16'hA5A5) begin
            failures++; $display("FAIL load_rdata got=%h exp=a5a5", d_rdata);
        end
    endtask

    task automatic test_tie();
        logic [15:0] exp_i, exp_d;
        mem_a[16'h0100] = 16'h1111;
        mem_a[16'h0200] = 16'h2222;
        do_reset();
`ifdef CRP16_MEM_ARB_RR_EN
        exp_i = 16'h0008; exp_d = 16'h0080;
`else
        exp_i = 16'h0080; exp_d = 16'h0008;
`endif
        start_cycle();
        i_addr = 16'h0100; d_addr = 16'h0200; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        capture(10, 1'b1);
        checks++;
        if (v_i_ack !== exp_i) begin
            failures++; $display("FAIL tie_iack got=%h exp=%h", v_i_ack, exp_i);
        end
        checks++;
        if (v_d_ack !== exp_d) begin
            failures++; $display("FAIL tie_dack got=%h exp=%h", v_d_ack, exp_d);
        end
        checks++;
        if (i_rdata !== 16'h1111 || d_rdata !== 16'h2222) begin
            failures++; $display("FAIL tie_rdata got=%h/%h exp=1111/2222", i_rdata, d_rdata);
        end
    endtask

    task automatic test_reset_wait();
        logic [15:0] bv_ack, bv_en;
        mem_b[16'h0050] = 16'hCAFE;
        mem_b[16'h0060] = 16'hBEAD;
        start_cycle();
        b_i_addr = 16'h0050; b_i_req = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (b_busy !== 1'b1) begin
            failures++; $display("FAIL rstwait_busy_pre got=%b exp=1", b_busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({b_busy, b_mem_en, b_mem_we, b_i_ack, b_d_ack} !== 5'b0 || b_i_rdata !== 16'h0) begin
            failures++;
            $display("FAIL rstwait_clear got=%b rdata=%h exp=00000 rdata=0000",
                     {b_busy, b_mem_en, b_mem_we, b_i_ack, b_d_ack}, b_i_rdata);
        end
        b_i_req = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        bv_ack = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            bv_ack[c] = b_i_ack;
        end
        checks++;
        if (bv_ack !== 16'h0) begin
            failures++; $display("FAIL rstwait_noack got=%h exp=0000", bv_ack);
        end
        start_cycle();
        b_i_addr = 16'h0060; b_i_req = 1'b1;
        bv_ack = '0; bv_en = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            bv_ack[c] = b_i_ack;
            bv_en[c]  = b_mem_en;
            if (b_i_ack) b_i_req = 1'b0;
        end
        checks++;
        if (bv_ack !== 16'h0020 || bv_en !== 16'h0002) begin
            failures++; $display("FAIL lat3_fetch ack=%h en=%h exp=0020/0002", bv_ack, bv_en);
        end
        checks++;
        if (b_i_rdata !== 16'hBEAD) begin
            failures++; $display("FAIL lat3_rdata got=%h exp=bead", b_i_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_i, exp_d;
        mem_a[16'h0300] = 16'h3333;
        mem_a[16'h0400] = 16'h4444;
        do_reset();
`ifdef CRP16_MEM_ARB_RR_EN
        exp_i = 16'h0808; exp_d = 16'h8080;
`else
        exp_i = 16'h0000; exp_d = 16'h8888;
`endif
        start_cycle();
        i_addr = 16'h0300; d_addr = 16'h0400; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        capture(16, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (v_i_ack !== exp_i) begin
            failures++; $display("FAIL b2b_iack got=%h exp=%h", v_i_ack, exp_i);
        end
        checks++;
        if (v_d_ack !== exp_d) begin
            failures++; $display("FAIL b2b_dack got=%h exp=%h", v_d_ack, exp_d);
        end
        checks++;
        if (v_busy !== 16'hEEEE || v_en !== 16'h2222) begin
            failures++; $display("FAIL b2b_busy_en got=%h/%h exp=eeee/2222", v_busy, v_en);
        end
        repeat (6) @(posedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_d_addr = '0; b_d_wdata = '0;
        b_p0 = '0; b_p1 = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_tie();
        test_reset_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
